// File: rtl/commit_unit.sv
// In-order retirement stage: drains one ROB head entry per cycle, writes the
// architectural register file, counts instret and sequences trap + flush.
module commit_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned INSTRET_WIDTH  = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ext_flush_i,
    input  logic                      commit_valid_i,
    output logic                      commit_ready_o,
    input  logic [PC_WIDTH-1:0]       commit_pc_i,
    input  logic [REG_ADDR_WIDTH-1:0] commit_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]     commit_result_i,
    input  logic                      commit_exception_valid_i,
    input  logic [31:0]               commit_exception_cause_i,
    output logic                      rf_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
    output logic                      trap_valid_o,
    input  logic                      trap_ready_i,
    output logic [PC_WIDTH-1:0]       trap_pc_o,
    output logic [31:0]               trap_cause_o,
    output logic                      flush_o,
    output logic [INSTRET_WIDTH-1:0]  instret_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP_REQ,
        ST_FLUSH
    } state_t;

    state_t                      r_state;
    logic                        r_rf_wr_en;
    logic [REG_ADDR_WIDTH-1:0]   r_rf_wr_addr;
    logic [DATA_WIDTH-1:0]       r_rf_wr_data;
    logic                        r_trap_valid;
    logic [PC_WIDTH-1:0]         r_trap_pc;
    logic [31:0]                 r_trap_cause;
    logic                        r_flush;
    logic [INSTRET_WIDTH-1:0]    r_instret;
    logic                        w_fire;

    // Ready is combinational so the ROB can see an external flush stall immediately.
    assign commit_ready_o = (r_state == ST_RUN) && !ext_flush_i;
    assign w_fire         = commit_valid_i && commit_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_RUN;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wr_data <= '0;
            r_trap_valid <= 1'b0;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
            r_flush      <= 1'b0;
            r_instret    <= '0;
        end else begin
            r_rf_wr_en <= 1'b0;
            r_flush    <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_fire) begin
                        if (commit_exception_valid_i) begin
                            r_trap_pc    <= commit_pc_i;
                            r_trap_cause <= commit_exception_cause_i;
                            r_trap_valid <= 1'b1;
                            r_state      <= ST_TRAP_REQ;
                        end else begin
                            r_instret <= r_instret + INSTRET_WIDTH'(1);
                            if (commit_rd_addr_i != '0) begin
                                r_rf_wr_en   <= 1'b1;
                                r_rf_wr_addr <= commit_rd_addr_i;
                                r_rf_wr_data <= commit_result_i;
                            end
                        end
                    end
                end
                ST_TRAP_REQ: begin
                    // Trap payload stays frozen until the trap unit takes it.
                    if (trap_ready_i) begin
                        r_trap_valid <= 1'b0;
                        r_flush      <= 1'b1;
                        r_state      <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign rf_wr_en_o   = r_rf_wr_en;
    assign rf_wr_addr_o = r_rf_wr_addr;
    assign rf_wr_data_o = r_rf_wr_data;
    assign trap_valid_o = r_trap_valid;
    assign trap_pc_o    = r_trap_pc;
    assign trap_cause_o = r_trap_cause;
    assign flush_o      = r_flush;
    assign instret_o    = r_instret;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios plus random traffic
// compared every cycle against a retirement reference model.
module tb_commit_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ext_flush_i;
    logic        commit_valid_i;
    logic        commit_ready_o;
    logic [31:0] commit_pc_i;
    logic [4:0]  commit_rd_addr_i;
    logic [31:0] commit_result_i;
    logic        commit_exception_valid_i;
    logic [31:0] commit_exception_cause_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic        trap_valid_o;
    logic        trap_ready_i;
    logic [31:0] trap_pc_o;
    logic [31:0] trap_cause_o;
    logic        flush_o;
    logic [63:0] instret_o;

    int checks = 0;
    int errors = 0;

    commit_unit dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .ext_flush_i              (ext_flush_i),
        .commit_valid_i           (commit_valid_i),
        .commit_ready_o           (commit_ready_o),
        .commit_pc_i              (commit_pc_i),
        .commit_rd_addr_i         (commit_rd_addr_i),
        .commit_result_i          (commit_result_i),
        .commit_exception_valid_i (commit_exception_valid_i),
        .commit_exception_cause_i (commit_exception_cause_i),
        .rf_wr_en_o               (rf_wr_en_o),
        .rf_wr_addr_o             (rf_wr_addr_o),
        .rf_wr_data_o             (rf_wr_data_o),
        .trap_valid_o             (trap_valid_o),
        .trap_ready_i             (trap_ready_i),
        .trap_pc_o                (trap_pc_o),
        .trap_cause_o             (trap_cause_o),
        .flush_o                  (flush_o),
        .instret_o                (instret_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: trap_pending / flush_due describe where retirement stands.
    logic        m_known = 1'b0;
    logic        m_trap_pending, m_flush_due;
    logic [63:0] m_instret;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_tpc, m_tcause;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic        can_retire, fire;
        logic        n_pending, n_flush, n_wen;
        logic [63:0] n_instret;
        logic [4:0]  n_waddr;
        logic [31:0] n_wdata, n_tpc, n_tcause;
        #1;
        can_retire = !m_trap_pending && !m_flush_due;
        fire = 1'b0;
        if (m_known) begin
            chk({tag, ".ready"}, 64'(commit_ready_o), 64'(can_retire && !ext_flush_i));
            fire = can_retire && !ext_flush_i && commit_valid_i;
        end
        n_pending = m_trap_pending; n_flush = 1'b0; n_wen = 1'b0;
        n_instret = m_instret; n_waddr = m_waddr; n_wdata = m_wdata;
        n_tpc = m_tpc; n_tcause = m_tcause;
        if (!rst_ni) begin
            n_pending = 1'b0; n_instret = '0; n_waddr = '0; n_wdata = '0;
            n_tpc = '0; n_tcause = '0;
        end else if (m_flush_due) begin
            n_flush = 1'b0;
        end else if (m_trap_pending) begin
            if (trap_ready_i) begin
                n_pending = 1'b0;
                n_flush   = 1'b1;
            end
        end else if (fire && commit_exception_valid_i) begin
            n_pending = 1'b1; n_tpc = commit_pc_i; n_tcause = commit_exception_cause_i;
        end else if (fire) begin
            n_instret = m_instret + 64'd1;
            if (commit_rd_addr_i != 5'd0) begin
                n_wen = 1'b1; n_waddr = commit_rd_addr_i; n_wdata = commit_result_i;
            end
        end
        @(posedge clk_i);
        #1;
        m_known = 1'b1;
        m_trap_pending = n_pending; m_flush_due = n_flush; m_wen = n_wen;
        m_instret = n_instret; m_waddr = n_waddr; m_wdata = n_wdata;
        m_tpc = n_tpc; m_tcause = n_tcause;
        chk({tag, ".rf_wr_en"},   64'(rf_wr_en_o),   64'(m_wen));
        chk({tag, ".rf_wr_addr"}, 64'(rf_wr_addr_o), 64'(m_waddr));
        chk({tag, ".rf_wr_data"}, 64'(rf_wr_data_o), 64'(m_wdata));
        chk({tag, ".trap_valid"}, 64'(trap_valid_o), 64'(m_trap_pending));
        chk({tag, ".trap_pc"},    64'(trap_pc_o),    64'(m_tpc));
        chk({tag, ".trap_cause"}, 64'(trap_cause_o), 64'(m_tcause));
        chk({tag, ".flush"},      64'(flush_o),      64'(m_flush_due));
        chk({tag, ".instret"},    instret_o,         m_instret);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res,
                         input logic exc, input logic [31:0] pc, input logic [31:0] cause);
        commit_valid_i = v; commit_rd_addr_i = rd; commit_result_i = res;
        commit_exception_valid_i = exc; commit_pc_i = pc; commit_exception_cause_i = cause;
    endtask

    initial begin
        m_trap_pending = 1'b0; m_flush_due = 1'b0; m_instret = '0; m_wen = 1'b0;
        m_waddr = '0; m_wdata = '0; m_tpc = '0; m_tcause = '0;
        rst_ni = 1'b0; ext_flush_i = 1'b0; trap_ready_i = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick("reset0");
        tick("reset1");
        rst_ni = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(9 + i), 1'b0, 32'(i * 4), 32'd0);
            tick("seq_write");
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick("seq_last");
        chk("seq_instret_is_4", instret_o, 64'd4);

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h40, 32'd0);
        tick("rd_zero");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        drive(1'b1, 5'd7, 32'h1234, 1'b1, 32'h0000_0100, 32'd2);
        tick("exc_fire");
        drive(1'b1, 5'd3, 32'h55, 1'b0, 32'h104, 32'd0);
        for (int i = 0; i < 3; i++) tick("trap_hold");
        chk("trap_pc_0x100", 64'(trap_pc_o), 64'h100);
        trap_ready_i = 1'b1;
        tick("trap_accept");
        trap_ready_i = 1'b0;
        tick("flush_cycle");
        tick("resume_fire");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        ext_flush_i = 1'b1;
        drive(1'b1, 5'd9, 32'hBEEF, 1'b0, 32'h200, 32'd0);
        tick("ext_flush_block");
        ext_flush_i = 1'b0;
        tick("ext_flush_release");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick("idle");

        for (int i = 0; i < 400; i++) begin
            ext_flush_i  = ($urandom_range(0, 5) == 0);
            trap_ready_i = ($urandom_range(0, 2) == 0);
            drive(1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                  $urandom, $urandom);
            tick("random");
        end
        ext_flush_i = 1'b0;
        trap_ready_i = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick("drain0");
        tick("drain1");
        tick("drain2");

        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1'b1, 5'd5, 32'h77, 1'b0, 32'h300, 32'd0);
        tick("instret_wrap");
        chk("instret_wrapped_zero", instret_o, 64'd0);

        trap_ready_i = 1'b0;
        drive(1'b1, 5'd6, 32'h88, 1'b1, 32'h400, 32'd11);
        tick("exc_before_reset");
        rst_ni = 1'b0;
        tick("reset_mid_trap");
        rst_ni = 1'b1;
        drive(1'b1, 5'd12, 32'hCAFE, 1'b0, 32'h500, 32'd0);
        tick("post_reset_commit");
        chk("post_reset_instret_1", instret_o, 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage on the head side of the reorder buffer; consumes the ROB commit handshake and drains one entry per cycle.
- Normal instructions: performs the architectural register-file write and counts retired instructions (instret).
- Excepting instructions: hands the trap to the CSR/trap unit, then issues a one-cycle pipeline flush before resuming.

Parameters:
DATA_WIDTH, XLEN (32), width of result / register-file write data
PC_WIDTH, ADDR_WIDTH (32), width of program counter
REG_ADDR_WIDTH, REG_ADDR_WIDTH (5), architectural register address width
INSTRET_WIDTH, 64, width of retired-instruction counter

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous active-low reset, sampled on rising clk_i
ext_flush_i  input  1  external flush request (branch mispredict); blocks retirement this cycle
commit_valid_i  input  1  ROB head entry valid and executed
commit_ready_o  output  1  commit unit accepts head entry this cycle
commit_pc_i  input  PC_WIDTH  PC of head entry
commit_rd_addr_i  input  REG_ADDR_WIDTH  destination register of head entry
commit_result_i  input  DATA_WIDTH  result of head entry
commit_exception_valid_i  input  1  head entry raised an exception
commit_exception_cause_i  input  32  exception cause code
rf_wr_en_o  output  1  register-file write enable (registered)
rf_wr_addr_o  output  REG_ADDR_WIDTH  register-file write address
rf_wr_data_o  output  DATA_WIDTH  register-file write data
trap_valid_o  output  1  trap request to CSR/trap unit
trap_ready_i  input  1  trap unit accepts request
trap_pc_o  output  PC_WIDTH  faulting PC (mepc value)
trap_cause_o  output  32  trap cause (mcause value)
flush_o  output  1  one-cycle flush pulse to ROB and front end
instret_o  output  INSTRET_WIDTH  count of retired (non-excepting) instructions

Behaviour:
- Reset (rst_ni low at rising edge): state=RUN. All outputs 0: rf_wr_*, trap_*, flush_o, instret_o. Reset has priority over every other input.
- A reset mid-trap (in TRAP_REQ or FLUSH) returns the block to RUN and drops trap_valid_o/flush_o at that edge.
- FSM states: RUN, TRAP_REQ, FLUSH.
- RUN:
  - commit_ready_o = !ext_flush_i; combinational, no dependence on commit_valid_i.
  - Handshake fire = commit_valid_i && commit_ready_o.
  - Fire without exception:
    - instret_o increments by 1 at the next edge; wraps modulo 2^INSTRET_WIDTH.
    - If commit_rd_addr_i != 0: rf_wr_en_o=1 next cycle, with rf_wr_addr_o/rf_wr_data_o latched from the commit inputs.
    - If commit_rd_addr_i == 0: no write, but instret still increments.
    - Back-to-back fires produce back-to-back writes; write latency is exactly 1 cycle.
  - Fire with exception:
    - No register write; instret unchanged.
    - Latch commit_pc_i → trap_pc_o and commit_exception_cause_i → trap_cause_o.
    - Go to TRAP_REQ.
  - rf_wr_en_o is 0 in any cycle not immediately following a non-exception fire with rd != 0.
- TRAP_REQ:
  - commit_ready_o=0; trap_valid_o=1.
  - trap_pc_o and trap_cause_o are held stable until accepted.
  - trap_ready_i=1 → go to FLUSH next edge; trap_valid_o drops at that edge.
  - ext_flush_i is ignored in this state.
- FLUSH:
  - commit_ready_o=0; flush_o=1 for exactly this one cycle.
  - Unconditionally go to RUN next edge.
- flush_o is 0 in every other state. ext_flush_i never drives flush_o; its owner flushes the ROB directly.
- ext_flush_i and commit_valid_i both high in RUN: no fire, no write, no instret change.
- Exception-to-resume latency when trap_ready_i is held high: fire cycle → TRAP_REQ (1 cycle) → FLUSH (1 cycle) → RUN. The first new fire is possible 3 cycles after the exception fire.
- Commit inputs are don't-care when commit_valid_i=0.

Test Plan:
- Reset, then 4 valid commits with rd=1..4 and results 0xA..0xD on consecutive cycles → rf writes (1,0xA)…(4,0xD) each 1 cycle after fire; instret_o=4.
- Commit with rd=0, result 0xFFFF_FFFF → rf_wr_en_o stays 0; instret_o increments by 1.
- Exception commit pc=0x0000_0100, cause=2; trap_ready_i held 0 for 3 cycles → trap_valid_o high for 4 cycles with trap_pc_o=0x100 and trap_cause_o=2; commit_ready_o=0 throughout; flush_o pulses one cycle after acceptance; instret_o unchanged; no rf write.
- ext_flush_i=1 with commit_valid_i=1 → commit_ready_o=0, no write, no instret change; ext_flush_i drops → commit fires next cycle.
- Preload instret to 2^64-1 by forcing, then one commit → instret_o=0.
- rst_ni low during TRAP_REQ → next edge all outputs 0, state RUN; subsequent valid commit retires normally.
